// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone RAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package wb_arb_pkg;

  // One-hot style encoding so the state doubles as the {m1,m0} owner vector
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  // Index of a master: 0 = CPU data bus, 1 = instruction bus
  typedef logic mst_idx_t;

  // Wishbone cycle type identifiers
  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts owner strobe cycles without a slave response.
// Latency: fire is combinational from the count; asserted for one cycle at TIMEOUT.
// Backpressure: none; the counter restarts on any ack/err, idle strobe or fire.
module wb_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic wb_clk,
  input  logic wb_rst_n,
  input  logic owner_stb,
  input  logic s_ack,
  input  logic s_err,
  output logic fire
);

  logic [15:0] count;

  assign fire = (count == 16'(TIMEOUT));

  // Count stalled strobe cycles; any response, strobe gap or fire restarts it
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      count <= 16'd0;
    end else if (s_ack || s_err || !owner_stb || fire) begin
      count <= 16'd0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the shared RAM; optional WB_ARB_TIMEOUT_EN watchdog.
// Latency: grant one cycle after cyc is sampled; data/ack routing is combinational from the owner.
// Backpressure: the losing master simply sees no ack until granted; ownership is held for the whole cyc.
module wb_ram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      owner_o
);

  state_t   owner;
  mst_idx_t last;
  logic     arb_edge;
  logic     owner_stb;
  logic     fire;

  // Re-arbitrate when idle or when the current owner has dropped cyc
  assign arb_edge = (owner == IDLE) ||
                    ((owner == OWN0) && !m0_cyc_i) ||
                    ((owner == OWN1) && !m1_cyc_i);

  assign owner_stb = ((owner == OWN0) && m0_cyc_i && m0_stb_i) ||
                     ((owner == OWN1) && m1_cyc_i && m1_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .wb_clk    (wb_clk),
    .wb_rst_n  (wb_rst_n),
    .owner_stb (owner_stb),
    .s_ack     (s_ack_i),
    .s_err     (s_err_i),
    .fire      (fire)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT == 0) ^ owner_stb;
  assign fire       = 1'b0;
`endif

  // Ownership FSM: release and regrant share one edge; ties go to the master not granted last
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      owner <= IDLE;
      last  <= 1'b1;
    end else if (arb_edge) begin
      if (m0_cyc_i && (!m1_cyc_i || last == 1'b1)) begin
        owner <= OWN0;
        last  <= 1'b0;
      end else if (m1_cyc_i) begin
        owner <= OWN1;
        last  <= 1'b1;
      end else begin
        owner <= IDLE;
      end
    end
  end

  assign owner_o  = {owner == OWN1, owner == OWN0};
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Route the owner's request to the slave and the slave response back to the owner only
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (owner)
      OWN0: begin
        s_cyc_o  = m0_cyc_i && !fire;
        s_stb_o  = m0_cyc_i && m0_stb_i && !fire;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i || fire;
      end
      OWN1: begin
        s_cyc_o  = m1_cyc_i && !fire;
        s_stb_o  = m1_cyc_i && m1_stb_i && !fire;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i || fire;
      end
      default: begin
      end
    endcase
  end

endmodule
